// File: rtl/rd_scoreboard_pkg.sv
// Shared widths and the in-flight entry layout for the destination scoreboard.
package rd_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int SB_NUM_REGS    = 32;
  localparam int SB_DEPTH       = 4;
  localparam int SB_CNT_WIDTH   = 3;

  // One in-flight instruction: does it write, and where.
  typedef struct packed {
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } sb_entry_t;

endpackage

// File: rtl/rd_scoreboard_sb_fifo.sv
// Program-order FIFO of in-flight destinations: pop oldest, kill N youngest,
// then push, all resolved in one cycle. Exposes the youngest DEPTH entries so
// the owner can undo their counters on a kill.
module sb_fifo
  import rd_scoreboard_pkg::*;
#(
  parameter int DEPTH     = SB_DEPTH,
  parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop,
  input  logic [CNT_WIDTH-1:0] kill_num,
  input  logic                 push,
  input  sb_entry_t            push_entry,
  output sb_entry_t            head_entry,
  output sb_entry_t            kill_entry [DEPTH],
  output logic [CNT_WIDTH-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sb_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     push_slot;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction

  // Head view and youngest-first kill view (slot k is the (k+1)-th youngest).
  always_comb begin
    head_entry = mem[head];
    for (int k = 0; k < DEPTH; k++) begin
      kill_entry[k] = mem[wrap(int'(tail) + DEPTH - 1 - k)];
    end
    // A push lands where the tail sits after any kill has retreated it.
    push_slot = wrap(int'(tail) + DEPTH - int'(kill_num));
  end

  // Pointer and occupancy update: pop, kill, push composed in one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (pop) head <= wrap(int'(head) + 1);
      tail      <= wrap(int'(tail) + DEPTH - int'(kill_num) + int'(push));
      occupancy <= occupancy - CNT_WIDTH'(pop) - kill_num + CNT_WIDTH'(push);
    end
  end

  // Entry storage; contents beyond occupancy are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[push_slot] <= push_entry;
  end

endmodule

// File: rtl/rd_scoreboard.sv
// Destination scoreboard: tracks pending writes per register between ID issue
// and WB commit, and raises the ID stall while a real producer is in flight.
// Inputs are single-cycle strobes sampled at posedge clk; there is no
// backpressure, so illegal requests set a sticky error instead of stalling.
module rd_scoreboard
  import rd_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int DEPTH     = SB_DEPTH,
  parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic                      id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs2_used,
  input  logic                      issue_valid,
  input  logic                      issue_wen,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic                      wb_valid,
  input  logic                      wb_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush_valid,
  input  logic [CNT_WIDTH-1:0]      flush_num,
  output logic                      stall_id,
  output logic                      full,
  output logic [CNT_WIDTH-1:0]      occupancy,
  output logic                      err_overflow,
  output logic                      err_order
);

  logic [CNT_WIDTH-1:0] cnt      [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_REGS];
  sb_entry_t            head_entry;
  sb_entry_t            kill_entry [DEPTH];
  sb_entry_t            push_entry;
  logic                 wb_pop, push, wb_wen_n;
  logic                 issue_err, flush_err, order_err;
  logic                 rs1_busy, rs2_busy;
  logic [CNT_WIDTH-1:0] removable, kill_cnt;

  sb_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .pop        (wb_pop),
    .kill_num   (kill_cnt),
    .push       (push),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .kill_entry (kill_entry),
    .occupancy  (occupancy)
  );

  // A source is busy if it stays pending after this cycle's write-through commit.
  function automatic logic src_busy(input logic [REG_ADDR_WIDTH-1:0] rs,
                                    input logic [CNT_WIDTH-1:0] c);
    logic releasing;
    releasing = wb_valid && wb_wen && (wb_rd == rs);
    return (rs != '0) && (c != '0) && !(releasing && c == CNT_WIDTH'(1));
  endfunction

  // Request decode: pop, kill count, push acceptance and error detection.
  always_comb begin
    full       = (occupancy == CNT_WIDTH'(DEPTH));
    wb_pop     = wb_valid && (occupancy != '0);
    wb_wen_n   = wb_wen && (wb_rd != '0);
    order_err  = wb_valid && ((occupancy == '0) ||
                 (head_entry.wen != wb_wen_n) ||
                 (head_entry.wen && head_entry.rd != wb_rd));
    removable  = occupancy - CNT_WIDTH'(wb_pop);
    kill_cnt   = '0;
    flush_err  = 1'b0;
    if (flush_valid) begin
      flush_err = (flush_num > removable);
      kill_cnt  = flush_err ? removable : flush_num;
    end
    push           = issue_valid && !flush_valid && (!full || wb_valid);
    issue_err      = issue_valid && !flush_valid && !push;
    push_entry.wen = issue_wen && (issue_rd != '0);
    push_entry.rd  = issue_rd;
    rs1_busy       = id_rs1_used && src_busy(id_rs1, cnt[id_rs1]);
    rs2_busy       = id_rs2_used && src_busy(id_rs2, cnt[id_rs2]);
    stall_id       = id_valid && (rs1_busy || rs2_busy || (full && !wb_valid));
  end

  // Net per-register count change: +push, -commit, -each killed entry.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = cnt[r];
      if (r != 0) begin
        if (push && push_entry.wen && push_entry.rd == REG_ADDR_WIDTH'(r))
          cnt_next[r] = cnt_next[r] + CNT_WIDTH'(1);
        if (wb_pop && head_entry.wen && head_entry.rd == REG_ADDR_WIDTH'(r))
          cnt_next[r] = cnt_next[r] - CNT_WIDTH'(1);
        for (int k = 0; k < DEPTH; k++) begin
          if (int'(kill_cnt) > k && kill_entry[k].wen &&
              kill_entry[k].rd == REG_ADDR_WIDTH'(r))
            cnt_next[r] = cnt_next[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter array and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      err_overflow <= 1'b0;
      err_order    <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      if (issue_err || flush_err) err_overflow <= 1'b1;
      if (order_err)              err_order    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_scoreboard.sv
// Directed bench for rd_scoreboard. Inputs change 1ns after posedge; combinational
// stall is probed a further 1ns later, registered outputs right after the edge.
module tb_rd_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2;
  logic       issue_valid, issue_wen;
  logic [4:0] issue_rd;
  logic       wb_valid, wb_wen;
  logic [4:0] wb_rd;
  logic       flush_valid;
  logic [2:0] flush_num;
  logic       stall_id, full, err_overflow, err_order;
  logic [2:0] occupancy;
  int         tests_run = 0;
  int         tests_failed = 0;

  rd_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .flush_valid(flush_valid), .flush_num(flush_num),
    .stall_id(stall_id), .full(full), .occupancy(occupancy),
    .err_overflow(err_overflow), .err_order(err_order)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    issue_valid = 0; issue_wen = 0; issue_rd = 0;
    wb_valid = 0; wb_wen = 0; wb_rd = 0;
    flush_valid = 0; flush_num = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_wen = 1; issue_rd = rd;
    step();
  endtask

  task automatic probe(input logic [4:0] rs);
    id_valid = 1; id_rs1 = rs; id_rs1_used = 1;
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_occ", 8'(occupancy), 8'd0);
    chk("reset_full", 8'(full), 8'd0);
    chk("reset_err_ovf", 8'(err_overflow), 8'd0);
    chk("reset_err_ord", 8'(err_order), 8'd0);
    probe(5'd3);
    chk("reset_stall_rs1_3", 8'(stall_id), 8'd0);
    idle();
  endtask

  task automatic test_raw_hazard();
    issue(5'd7);
    chk("raw_occ1", 8'(occupancy), 8'd1);
    id_valid = 1; id_rs2 = 7; id_rs2_used = 1;
    #1;
    chk("raw_stall", 8'(stall_id), 8'd1);
    wb_valid = 1; wb_wen = 1; wb_rd = 7;
    #1;
    chk("raw_stall_release_same_cycle", 8'(stall_id), 8'd0);
    step();
    chk("raw_occ0", 8'(occupancy), 8'd0);
    chk("raw_err_ord", 8'(err_order), 8'd0);
  endtask

  task automatic test_x0();
    issue(5'd0);
    probe(5'd0);
    chk("x0_stall", 8'(stall_id), 8'd0);
    chk("x0_occ1", 8'(occupancy), 8'd1);
    idle();
    wb_valid = 1; wb_wen = 0; wb_rd = 0;
    step();
    chk("x0_occ0", 8'(occupancy), 8'd0);
    chk("x0_err_ord", 8'(err_order), 8'd0);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) issue(5'(i));
    chk("full_flag", 8'(full), 8'd1);
    chk("full_occ4", 8'(occupancy), 8'd4);
    probe(5'd10);
    chk("full_stall_unrelated", 8'(stall_id), 8'd1);
    wb_valid = 1; wb_wen = 1; wb_rd = 1;
    #1;
    chk("full_stall_with_wb", 8'(stall_id), 8'd0);
    idle();
    issue(5'd8);
    chk("full_drop_occ", 8'(occupancy), 8'd4);
    chk("full_drop_err_ovf", 8'(err_overflow), 8'd1);
    issue_valid = 1; issue_wen = 1; issue_rd = 8;
    wb_valid = 1; wb_wen = 1; wb_rd = 1;
    step();
    chk("full_swap_occ", 8'(occupancy), 8'd4);
    chk("full_swap_err_ord", 8'(err_order), 8'd0);
    // Remaining order is 2,3,4,8.
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1; wb_wen = 1;
      wb_rd = (i == 3) ? 5'd8 : 5'(i + 2);
      step();
    end
    chk("full_drain_occ", 8'(occupancy), 8'd0);
    chk("full_drain_err_ord", 8'(err_order), 8'd0);
    probe(5'd8);
    chk("full_drain_stall8", 8'(stall_id), 8'd0);
    idle();
    do_reset();
    chk("full_reset_err_ovf", 8'(err_overflow), 8'd0);
  endtask

  task automatic test_flush();
    issue(5'd5); issue(5'd6); issue(5'd5);
    flush_valid = 1; flush_num = 2;
    issue_valid = 1; issue_wen = 1; issue_rd = 12;
    step();
    chk("flush_occ1", 8'(occupancy), 8'd1);
    chk("flush_err_ovf", 8'(err_overflow), 8'd0);
    probe(5'd6);
    chk("flush_cnt6_zero", 8'(stall_id), 8'd0);
    probe(5'd12);
    chk("flush_issue_ignored", 8'(stall_id), 8'd0);
    probe(5'd5);
    chk("flush_cnt5_nonzero", 8'(stall_id), 8'd1);
    wb_valid = 1; wb_wen = 1; wb_rd = 5;
    #1;
    chk("flush_cnt5_is_one", 8'(stall_id), 8'd0);
    idle();
    flush_valid = 1; flush_num = 3;
    step();
    chk("flush_over_occ", 8'(occupancy), 8'd0);
    chk("flush_over_err_ovf", 8'(err_overflow), 8'd1);
    probe(5'd5);
    chk("flush_over_cnt5", 8'(stall_id), 8'd0);
    idle();
    do_reset();
  endtask

  task automatic test_same_cycle();
    issue(5'd5);
    issue_valid = 1; issue_wen = 1; issue_rd = 5;
    wb_valid = 1; wb_wen = 1; wb_rd = 5;
    step();
    chk("same_occ1", 8'(occupancy), 8'd1);
    probe(5'd5);
    chk("same_cnt5_nonzero", 8'(stall_id), 8'd1);
    wb_valid = 1; wb_wen = 1; wb_rd = 5;
    #1;
    chk("same_cnt5_is_one", 8'(stall_id), 8'd0);
    step();
    chk("same_err_ord", 8'(err_order), 8'd0);
    do_reset();
  endtask

  task automatic test_order();
    issue(5'd9);
    probe(5'd9);
    chk("order_stall9", 8'(stall_id), 8'd1);
    idle();
    wb_valid = 1; wb_wen = 1; wb_rd = 10;
    step();
    chk("order_popped", 8'(occupancy), 8'd0);
    chk("order_err", 8'(err_order), 8'd1);
    probe(5'd9);
    chk("order_cnt9_released", 8'(stall_id), 8'd0);
    idle();
    step(); step();
    chk("order_err_sticky", 8'(err_order), 8'd1);
    do_reset();
    chk("order_err_cleared", 8'(err_order), 8'd0);
    wb_valid = 1; wb_wen = 1; wb_rd = 3;
    step();
    chk("order_empty_wb_err", 8'(err_order), 8'd1);
    chk("order_empty_wb_occ", 8'(occupancy), 8'd0);
  endtask

  task automatic test_reset_midop();
    issue(5'd4); issue(5'd11);
    rst = 1;
    issue_valid = 1; issue_wen = 1; issue_rd = 13;
    wb_valid = 1; wb_wen = 1; wb_rd = 4;
    step();
    rst = 0;
    chk("midrst_occ", 8'(occupancy), 8'd0);
    chk("midrst_err_ord", 8'(err_order), 8'd0);
    probe(5'd11);
    chk("midrst_stall11", 8'(stall_id), 8'd0);
    idle();
  endtask

  // Sequencer and final report
  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_raw_hazard();
    test_x0();
    test_full();
    test_flush();
    test_same_cycle();
    test_order();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
